// File: rtl/bus_txn_ctrl.sv
// Slave-side bus transaction sequencer.
// Decodes the granted master's address onto 8 active-low chip selects, inserts
// per-slave programmable wait states, waits for slave ready and returns a one-cycle
// ready pulse to the master.
// Optional feature macro: BUS_TIMEOUT_EN builds the ACCESS timeout watchdog, which
// terminates a hung access with rdy_=0 and err=1. Without it err is tied low.
module bus_txn_ctrl #(
  parameter int unsigned ADDR_W  = 30,
  parameter int unsigned WAIT_W  = 4,
  parameter int unsigned TO_W    = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              as_,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        slv_rdy_,
  output logic [7:0]        slv_cs_,
  output logic              rdy_,
  output logic              err,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_sel,
  input  logic [WAIT_W-1:0] cfg_wait
);

  // Catch an out-of-range timeout at elaboration.
  if (TIMEOUT == 0 || TIMEOUT >= (2 ** TO_W)) begin : gen_bad_timeout
    $error("bus_txn_ctrl: TIMEOUT must be in 1..2**TO_W-1");
  end

  typedef enum logic [1:0] {StIdle, StAccess, StResp, StErr} state_e;

  state_e            state;
  logic [2:0]        sel;
  logic [WAIT_W-1:0] wcnt;
  logic [WAIT_W-1:0] wait_tbl [8];
  logic [2:0]        addr_sel;

  assign addr_sel = addr[ADDR_W-1 -: 3];

`ifdef BUS_TIMEOUT_EN
  logic [TO_W-1:0] tcnt;
  logic            to_hit;

  assign to_hit = (tcnt == TO_W'(TIMEOUT - 1));

  // Count ACCESS cycles (wait states included), saturating; cleared while idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tcnt <= '0;
    end else if (state == StAccess) begin
      if (tcnt != '1) tcnt <= tcnt + 1'b1;
    end else begin
      tcnt <= '0;
    end
  end
`else
  assign err = 1'b0;
`endif

  // Wait-state table; writable in any state, read only at transaction start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) wait_tbl[i] <= '0;
    end else if (cfg_we) begin
      wait_tbl[cfg_sel] <= cfg_wait;
    end
  end

  // Transaction FSM with registered chip selects, ready and error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= StIdle;
      sel     <= '0;
      wcnt    <= '0;
      slv_cs_ <= 8'hFF;
      rdy_    <= 1'b1;
`ifdef BUS_TIMEOUT_EN
      err     <= 1'b0;
`endif
    end else begin
      unique case (state)
        StIdle: begin
          if (!as_) begin
            sel     <= addr_sel;
            wcnt    <= wait_tbl[addr_sel];
            slv_cs_ <= ~(8'b1 << addr_sel);
            state   <= StAccess;
          end
        end
        StAccess: begin
          if (as_) begin
            // Master abort: drop the select silently.
            slv_cs_ <= 8'hFF;
            state   <= StIdle;
          end else if (wcnt != '0) begin
            wcnt <= wcnt - 1'b1;
          end else if (!slv_rdy_[sel]) begin
            // Ready has priority over a coincident timeout.
            rdy_    <= 1'b0;
            slv_cs_ <= 8'hFF;
            state   <= StResp;
`ifdef BUS_TIMEOUT_EN
          end else if (to_hit) begin
            rdy_    <= 1'b0;
            err     <= 1'b1;
            slv_cs_ <= 8'hFF;
            state   <= StErr;
`endif
          end
        end
        StResp, StErr: begin
          rdy_  <= 1'b1;
`ifdef BUS_TIMEOUT_EN
          err   <= 1'b0;
`endif
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_txn_ctrl.sv
// Directed self-checking bench for bus_txn_ctrl.
// Outputs are sampled 1 ns after each rising edge; inputs change at the same point so
// the next rising edge samples them.
module tb_bus_txn_ctrl;

  localparam int unsigned ADDR_W = 30;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              as_;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        slv_rdy_;
  logic [7:0]        slv_cs_;
  logic              rdy_;
  logic              err;
  logic              cfg_we;
  logic [2:0]        cfg_sel;
  logic [3:0]        cfg_wait;

  int tests = 0;
  int fails = 0;

  bus_txn_ctrl #(
    .ADDR_W (ADDR_W),
    .WAIT_W (4),
    .TO_W   (8),
    .TIMEOUT(16)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .as_     (as_),
    .addr    (addr),
    .slv_rdy_(slv_rdy_),
    .slv_cs_ (slv_cs_),
    .rdy_    (rdy_),
    .err     (err),
    .cfg_we  (cfg_we),
    .cfg_sel (cfg_sel),
    .cfg_wait(cfg_wait)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] cs, input logic r,
                         input logic e);
    chk({tag, ".cs"}, slv_cs_, cs);
    chk({tag, ".rdy"}, {7'b0, rdy_}, {7'b0, r});
    chk({tag, ".err"}, {7'b0, err}, {7'b0, e});
  endtask

  task automatic start(input logic [2:0] s);
    addr = {s, 27'h15A5A5A};
    as_  = 1'b0;
  endtask

  task automatic cfg(input logic [2:0] s, input logic [3:0] w);
    cfg_we   = 1'b1;
    cfg_sel  = s;
    cfg_wait = w;
    tick();
    cfg_we   = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    as_      = 1'b0;
    addr     = {3'd3, 27'h0};
    slv_rdy_ = 8'h00;
    cfg_we   = 1'b0;
    cfg_sel  = '0;
    cfg_wait = '0;

    // T1: reset held with as_ low.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("t1_rst", 8'hFF, 1'b1, 1'b0);
    end
    rst_n = 1'b1;
    as_   = 1'b1;
    tick();
    chk_out("t1_idle", 8'hFF, 1'b1, 1'b0);

    // T2: zero-wait access to slave 2.
    slv_rdy_ = 8'hFB;
    start(3'd2);
    tick();
    chk_out("t2_cs", 8'hFB, 1'b1, 1'b0);
    tick();
    chk_out("t2_rdy", 8'hFF, 1'b0, 1'b0);
    as_ = 1'b1;
    tick();
    chk_out("t2_resp", 8'hFF, 1'b1, 1'b0);

    // T3: three wait states on slave 5; ready held low is ignored during waits.
    cfg(3'd5, 4'd3);
    slv_rdy_ = 8'hDF;
    start(3'd5);
    tick();
    chk_out("t3_cs", 8'hDF, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("t3_wait", 8'hDF, 1'b1, 1'b0);
    end
    tick();
    chk_out("t3_rdy", 8'hFF, 1'b0, 1'b0);
    as_ = 1'b1;
    tick();
    chk_out("t3_resp", 8'hFF, 1'b1, 1'b0);

    // T5a: abort raised on the third cycle of a waiting access.
    slv_rdy_ = 8'hFF;
    start(3'd5);
    tick();
    chk_out("t5_cs", 8'hDF, 1'b1, 1'b0);
    tick();
    tick();
    chk_out("t5_wait", 8'hDF, 1'b1, 1'b0);
    as_ = 1'b1;
    tick();
    chk_out("t5_abort", 8'hFF, 1'b1, 1'b0);
    tick();
    chk_out("t5_idle", 8'hFF, 1'b1, 1'b0);

    // T6: back-to-back with a wait-table write during the first access.
    cfg(3'd0, 4'd1);
    slv_rdy_ = 8'hFC;
    start(3'd0);
    tick();
    chk_out("t6a_cs", 8'hFE, 1'b1, 1'b0);
    cfg(3'd0, 4'd4);
    chk_out("t6a_wait", 8'hFE, 1'b1, 1'b0);
    tick();
    chk_out("t6a_rdy", 8'hFF, 1'b0, 1'b0);
    as_ = 1'b1;
    tick();
    chk_out("t6a_resp", 8'hFF, 1'b1, 1'b0);
    start(3'd1);
    tick();
    chk_out("t6b_cs", 8'hFD, 1'b1, 1'b0);
    tick();
    chk_out("t6b_rdy", 8'hFF, 1'b0, 1'b0);
    start(3'd0);
    tick();
    chk_out("t6b_resp", 8'hFF, 1'b1, 1'b0);
    // New wait value of 4 applies to the next slave-0 access.
    tick();
    chk_out("t6c_cs", 8'hFE, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out("t6c_wait", 8'hFE, 1'b1, 1'b0);
    end
    tick();
    chk_out("t6c_rdy", 8'hFF, 1'b0, 1'b0);
    as_ = 1'b1;
    tick();
    chk_out("t6c_resp", 8'hFF, 1'b1, 1'b0);

`ifdef BUS_TIMEOUT_EN
    // T4: slave 7 never ready; error after 16 ACCESS cycles.
    slv_rdy_ = 8'hFF;
    start(3'd7);
    tick();
    chk_out("t4_cs", 8'h7F, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) begin
      tick();
      chk_out("t4_wait", 8'h7F, 1'b1, 1'b0);
    end
    tick();
    chk_out("t4_err", 8'hFF, 1'b0, 1'b1);
    as_ = 1'b1;
    tick();
    chk_out("t4_errend", 8'hFF, 1'b1, 1'b0);

    // T5b: ready arrives on the timeout cycle; ready wins.
    start(3'd7);
    tick();
    for (int i = 0; i < 15; i++) tick();
    chk_out("t5b_pre", 8'h7F, 1'b1, 1'b0);
    slv_rdy_ = 8'h7F;
    tick();
    chk_out("t5b_rdy", 8'hFF, 1'b0, 1'b0);
    as_ = 1'b1;
    tick();
    chk_out("t5b_resp", 8'hFF, 1'b1, 1'b0);
`else
    // Without the watchdog an unanswered access waits until the master aborts.
    slv_rdy_ = 8'hFF;
    start(3'd7);
    tick();
    chk_out("nto_cs", 8'h7F, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) begin
      tick();
      chk_out("nto_wait", 8'h7F, 1'b1, 1'b0);
    end
    as_ = 1'b1;
    tick();
    chk_out("nto_abort", 8'hFF, 1'b1, 1'b0);
`endif

    // Reset mid-access: no pulse, and the wait table returns to zero.
    slv_rdy_ = 8'hFF;
    start(3'd5);
    tick();
    chk_out("rst_cs", 8'hDF, 1'b1, 1'b0);
    rst_n = 1'b0;
    slv_rdy_ = 8'hDF;
    tick();
    chk_out("rst_abort", 8'hFF, 1'b1, 1'b0);
    rst_n = 1'b1;
    as_   = 1'b1;
    tick();
    chk_out("rst_quiet", 8'hFF, 1'b1, 1'b0);
    start(3'd5);
    tick();
    chk_out("rst_cs2", 8'hDF, 1'b1, 1'b0);
    tick();
    chk_out("rst_tbl0", 8'hFF, 1'b0, 1'b0);
    as_ = 1'b1;
    tick();
    chk_out("rst_end", 8'hFF, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
